// File: rtl/serial_parallel_right_deserializer.sv
// Rebuilds LSB-first serial words from the right-shift register stream.
// Each completed word is offered on a valid/ready port. A sticky overrun flag marks words dropped under back-pressure.
module serial_parallel_right_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             start,
    input  logic             serial_in,
    input  logic             ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word_c;
    logic             done_c;

    assign word_c = {serial_in, sr_q[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame assembly. A start seen mid-frame restarts the word at bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_en && start) begin
                    sr_d    = word_c;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample_en) begin
                    sr_d = word_c;
                    if (start) begin
                        cnt_d = CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register. A word that completes while the slot is still occupied and not draining is dropped.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q && !clear_overrun;
        if (done_c) begin
            if (!valid_q || ready) begin
                data_d  = word_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q == ST_SHIFT);

endmodule
